// File: rtl/instr_issuer_if.sv
// ---------------------------------------------------------------------------
// instr_issuer_if
//
// Instruction interface between the issuer (producer) and the CPU (consumer).
//   instruction  issuer -> cpu   issued word {opcode[4:0], imm[10:0]}
//   instr_valid  issuer -> cpu   instruction is valid
//   pc           issuer -> cpu   address of the word being fetched or issued
//   instr_ready  cpu -> issuer   CPU accepts the word this cycle
//   pc_load      cpu -> issuer   redirect request (one-cycle pulse)
//   pc_target    cpu -> issuer   redirect address
// ---------------------------------------------------------------------------
interface instr_issuer_if #(
  parameter int WIDTH_DATA = 16,
  parameter int AWIDTH     = 5
);
  logic [WIDTH_DATA-1:0] instruction;
  logic                  instr_valid;
  logic [AWIDTH-1:0]     pc;
  logic                  instr_ready;
  logic                  pc_load;
  logic [AWIDTH-1:0]     pc_target;

  modport master (
    output instruction, instr_valid, pc,
    input  instr_ready, pc_load, pc_target
  );

  modport slave (
    input  instruction, instr_valid, pc,
    output instr_ready, pc_load, pc_target
  );
endinterface

// File: rtl/instr_issuer.sv
// ---------------------------------------------------------------------------
// instr_issuer
//
// Fetches 16-bit words from a loadable program memory and presents them to
// the CPU over a valid/ready handshake. Follows CPU redirects and stops when
// a HALT_OP word is fetched (that word is never issued).
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   load_en    program write strobe (only honoured in IDLE/HALT)
//   load_addr  program write address
//   load_data  program write data
//   start      begin execution at address 0 (only honoured in IDLE/HALT)
//   cpu        instruction interface, master side (instruction, instr_valid,
//              pc out; instr_ready, pc_load, pc_target in)
//   busy       high in FETCH or ISSUE
//   halted     high in HALT
// ---------------------------------------------------------------------------
module instr_issuer #(
  parameter int         WIDTH_DATA = 16,
  parameter int         AWIDTH     = 5,
  parameter logic [4:0] HALT_OP    = 5'd31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [AWIDTH-1:0]     load_addr,
  input  logic [WIDTH_DATA-1:0] load_data,
  input  logic                  start,
  instr_issuer_if.master        cpu,
  output logic                  busy,
  output logic                  halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int DEPTH = 1 << AWIDTH;

  state_t                state_reg, state_next;
  logic [AWIDTH-1:0]     pc_reg, pc_next;
  logic [WIDTH_DATA-1:0] instr_reg, instr_next;
  logic                  valid_reg, valid_next;
  // fresh_reg: the read data register already holds mem[pc_reg].
  logic                  fresh_reg, fresh_next;

  logic [WIDTH_DATA-1:0] mem [0:DEPTH-1];
  logic [WIDTH_DATA-1:0] rd_data_reg;
  logic [AWIDTH-1:0]     rd_addr;
  logic                  mem_we;
  logic                  transfer;
  logic                  rd_is_halt;
  logic                  can_load;

  assign can_load   = (state_reg == S_IDLE) || (state_reg == S_HALT);
  assign mem_we     = load_en && can_load;
  assign transfer   = valid_reg && cpu.instr_ready;
  assign rd_is_halt = (rd_data_reg[WIDTH_DATA-1 -: 5] == HALT_OP);

  // While a word is on offer, prefetch the next sequential address so that a
  // plain transfer leads straight into a FETCH that already has its data.
  // Start and redirects land on an address that has not been read yet, so
  // they spend one extra FETCH cycle waiting for the read.
  assign rd_addr = (state_reg == S_ISSUE) ? pc_reg + AWIDTH'(1) : pc_reg;

  // Program memory: synchronous write, registered read, not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_addr] <= load_data;
    end
    rd_data_reg <= mem[rd_addr];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (cpu.pc_load) begin
          state_next = S_FETCH;
        end else if (fresh_reg) begin
          state_next = rd_is_halt ? S_HALT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cpu.pc_load || transfer) begin
          state_next = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output / datapath control logic
  always_comb begin
    pc_next    = pc_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
    fresh_next = fresh_reg;
    busy       = (state_reg == S_FETCH) || (state_reg == S_ISSUE);
    halted     = (state_reg == S_HALT);
    case (state_reg)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_next    = '0;
          valid_next = 1'b0;
          fresh_next = 1'b0;
        end
      end
      S_FETCH: begin
        if (cpu.pc_load) begin
          // Drop the in-flight read and restart at the target.
          pc_next    = cpu.pc_target;
          fresh_next = 1'b0;
        end else if (fresh_reg) begin
          if (!rd_is_halt) begin
            instr_next = rd_data_reg;
            valid_next = 1'b1;
          end
        end else begin
          fresh_next = 1'b1;
        end
      end
      S_ISSUE: begin
        if (cpu.pc_load) begin
          // Covers both a discarded pending word and a redirect coincident
          // with a transfer: the target wins over pc+1 either way.
          pc_next    = cpu.pc_target;
          valid_next = 1'b0;
          fresh_next = 1'b0;
        end else if (transfer) begin
          pc_next    = pc_reg + AWIDTH'(1);
          valid_next = 1'b0;
          fresh_next = 1'b1;
        end
      end
      default: begin
        valid_next = 1'b0;
        fresh_next = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg    <= '0;
      instr_reg <= '0;
      valid_reg <= 1'b0;
      fresh_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
      fresh_reg <= fresh_next;
    end
  end

  assign cpu.instruction = instr_reg;
  assign cpu.instr_valid = valid_reg;
  assign cpu.pc          = pc_reg;

endmodule

// File: tb/tb_instr_issuer.sv
// ---------------------------------------------------------------------------
// tb_instr_issuer
//
// Self-checking bench for instr_issuer. Expected (instruction, pc) pairs are
// queued when stimulus is driven and popped by a monitor on each transfer.
// Scenario tasks add their own timing and state checks.
// ---------------------------------------------------------------------------
module tb_instr_issuer;
  localparam int WD = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [WD-1:0] load_data = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          halted;

  instr_issuer_if #(.WIDTH_DATA(WD), .AWIDTH(AW)) ifc ();

  instr_issuer #(.WIDTH_DATA(WD), .AWIDTH(AW), .HALT_OP(5'd31)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .cpu       (ifc.master),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WD-1:0] instr;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic          hold_prev = 1'b0;
  logic [WD-1:0] prev_instr = '0;
  logic [AW-1:0] prev_pc = '0;

  // Transfer monitor: scoreboard compare, halt-word guard, hold stability.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (ifc.instr_valid !== 1'b1 || ifc.instruction !== prev_instr || ifc.pc !== prev_pc) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b instr=%h pc=%0d, expected valid=1 instr=%h pc=%0d",
                   ifc.instr_valid, ifc.instruction, ifc.pc, prev_instr, prev_pc);
        end
      end
      if (ifc.instr_valid === 1'b1) begin
        checks++;
        if (ifc.instruction[15:11] === 5'd31) begin
          errors++;
          $display("FAIL halt_word_issued: got instr=%h, expected no HALT opcode on a valid word",
                   ifc.instruction);
        end
        if (ifc.instr_ready === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_xfer: got instr=%h pc=%0d, expected no transfer",
                     ifc.instruction, ifc.pc);
          end else begin
            mon_e = sb.pop_front();
            if (ifc.instruction !== mon_e.instr || ifc.pc !== mon_e.pc) begin
              errors++;
              $display("FAIL xfer: got instr=%h pc=%0d, expected instr=%h pc=%0d",
                       ifc.instruction, ifc.pc, mon_e.instr, mon_e.pc);
            end else begin
              $display("xfer  pc=%0d instr=%h", ifc.pc, ifc.instruction);
            end
          end
        end
      end
      hold_prev  = (ifc.instr_valid === 1'b1) && (ifc.instr_ready === 1'b0) && (ifc.pc_load === 1'b0);
      prev_instr = ifc.instruction;
      prev_pc    = ifc.pc;
    end
  end

  // ---------------- stimulus helpers (drive only, plus bounded waits) -------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [WD-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [WD-1:0] i, input logic [AW-1:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (ifc.instr_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ifc.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_valid: got valid=%b after %0d cycles, expected 1", tag, ifc.instr_valid, n);
    end
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (halted !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_halt: got halted=%b after %0d cycles, expected 1", tag, halted, n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    checks++;
    if (ifc.instr_valid !== 1'b0 || ifc.pc !== '0 || ifc.instruction !== '0 || busy !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got valid=%b pc=%0d instr=%h busy=%b halted=%b, expected all 0",
               ifc.instr_valid, ifc.pc, ifc.instruction, busy, halted);
    end
    tick();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || ifc.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b halted=%b valid=%b, expected 0 0 0", busy, halted, ifc.instr_valid);
    end
  endtask

  task automatic test_basic_program();
    logic [8:0] vpat;
    vpat = 9'b001010100; // bit k: valid expected k edges after start
    load_word(5'd0, 16'h0805);
    load_word(5'd1, 16'h0802);
    load_word(5'd2, 16'h2000);
    load_word(5'd3, 16'hF800);
    ifc.instr_ready = 1'b1;
    push(16'h0805, 5'd0);
    push(16'h0802, 5'd1);
    push(16'h2000, 5'd2);
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (ifc.instr_valid !== vpat[k] || halted !== (k == 8)) begin
        errors++;
        $display("FAIL basic_timing[%0d]: got valid=%b halted=%b, expected valid=%b halted=%b",
                 k, ifc.instr_valid, halted, vpat[k], (k == 8));
      end
      if (k == 8) begin
        checks++;
        if (ifc.pc !== 5'd3 || busy !== 1'b0) begin
          errors++;
          $display("FAIL basic_halt_pc: got pc=%0d busy=%b, expected pc=3 busy=0", ifc.pc, busy);
        end
      end else begin
        tick();
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL basic_drained: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    ifc.instr_ready = 1'b0;
    push(16'h0805, 5'd0);
    push(16'h0802, 5'd1);
    push(16'h2000, 5'd2);
    pulse_start();
    wait_valid("bp");
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ifc.instr_valid !== 1'b1 || ifc.instruction !== 16'h0805 || ifc.pc !== 5'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b instr=%h pc=%0d, expected 1 0805 0",
                 k, ifc.instr_valid, ifc.instruction, ifc.pc);
      end
      tick();
    end
    ifc.instr_ready = 1'b1;
    wait_halt("bp");
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drained: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_redirect();
    ifc.instr_ready = 1'b0;
    push(16'h0805, 5'd0);
    pulse_start();
    wait_valid("rd1");
    ifc.instr_ready = 1'b1;
    tick();
    ifc.instr_ready = 1'b0;
    wait_valid("rd2");
    checks++;
    if (ifc.instruction !== 16'h0802 || ifc.pc !== 5'd1) begin
      errors++;
      $display("FAIL rd_pending: got instr=%h pc=%0d, expected 0802 1", ifc.instruction, ifc.pc);
    end
    // Redirect while 0x0802 is pending: it is dropped.
    ifc.pc_target = 5'd0;
    ifc.pc_load   = 1'b1;
    tick();
    ifc.pc_load = 1'b0;
    checks++;
    if (ifc.instr_valid !== 1'b0 || ifc.pc !== 5'd0) begin
      errors++;
      $display("FAIL rd_drop: got valid=%b pc=%0d, expected valid=0 pc=0", ifc.instr_valid, ifc.pc);
    end
    tick();
    checks++;
    if (ifc.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_latency1: got valid=%b, expected 0", ifc.instr_valid);
    end
    tick();
    checks++;
    if (ifc.instr_valid !== 1'b1 || ifc.instruction !== 16'h0805 || ifc.pc !== 5'd0) begin
      errors++;
      $display("FAIL rd_latency2: got valid=%b instr=%h pc=%0d, expected 1 0805 0",
               ifc.instr_valid, ifc.instruction, ifc.pc);
    end
    // Redirect coincident with the transfer of 0x0802.
    push(16'h0805, 5'd0);
    ifc.instr_ready = 1'b1;
    tick();
    ifc.instr_ready = 1'b0;
    wait_valid("rd3");
    push(16'h0802, 5'd1);
    push(16'h0805, 5'd0);
    ifc.instr_ready = 1'b1;
    ifc.pc_load     = 1'b1;
    tick();
    ifc.pc_load     = 1'b0;
    ifc.instr_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (ifc.instr_valid !== 1'b1 || ifc.instruction !== 16'h0805 || ifc.pc !== 5'd0) begin
      errors++;
      $display("FAIL rd_coincident: got valid=%b instr=%h pc=%0d, expected 1 0805 0",
               ifc.instr_valid, ifc.instruction, ifc.pc);
    end
    push(16'h0802, 5'd1);
    push(16'h2000, 5'd2);
    ifc.instr_ready = 1'b1;
    wait_halt("rd");
    checks++;
    if (sb.size() != 0 || ifc.pc !== 5'd3) begin
      errors++;
      $display("FAIL rd_end: got pending=%0d pc=%0d, expected 0 3", sb.size(), ifc.pc);
    end
  endtask

  task automatic test_wrap();
    load_word(5'd31, 16'h0801);
    load_word(5'd0, 16'h0803);
    ifc.instr_ready = 1'b0;
    pulse_start();
    wait_valid("wrap");
    ifc.pc_target = 5'd31;
    ifc.pc_load   = 1'b1;
    tick();
    ifc.pc_load = 1'b0;
    push(16'h0801, 5'd31);
    push(16'h0803, 5'd0);
    push(16'h0802, 5'd1);
    push(16'h2000, 5'd2);
    ifc.instr_ready = 1'b1;
    wait_halt("wrap");
    checks++;
    if (sb.size() != 0 || ifc.pc !== 5'd3) begin
      errors++;
      $display("FAIL wrap_end: got pending=%0d pc=%0d, expected 0 3", sb.size(), ifc.pc);
    end
  endtask

  task automatic test_async_reset();
    ifc.instr_ready = 1'b0;
    pulse_start();
    wait_valid("ares");
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (ifc.instr_valid !== 1'b0 || ifc.pc !== '0 || ifc.instruction !== '0 || busy !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b pc=%0d instr=%h busy=%b halted=%b, expected all 0",
               ifc.instr_valid, ifc.pc, ifc.instruction, busy, halted);
    end
    sb.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || ifc.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b halted=%b valid=%b, expected 0 0 0",
               busy, halted, ifc.instr_valid);
    end
    push(16'h0803, 5'd0);
    push(16'h0802, 5'd1);
    push(16'h2000, 5'd2);
    ifc.instr_ready = 1'b1;
    pulse_start();
    wait_halt("ares");
    checks++;
    if (sb.size() != 0 || ifc.pc !== 5'd3) begin
      errors++;
      $display("FAIL ares_end: got pending=%0d pc=%0d, expected 0 3", sb.size(), ifc.pc);
    end
  endtask

  task automatic test_halt_reload();
    // Redirect is ignored in HALT.
    ifc.pc_target = 5'd5;
    ifc.pc_load   = 1'b1;
    tick();
    ifc.pc_load = 1'b0;
    checks++;
    if (halted !== 1'b1 || ifc.pc !== 5'd3) begin
      errors++;
      $display("FAIL halt_ignore_redirect: got halted=%b pc=%0d, expected 1 3", halted, ifc.pc);
    end
    load_word(5'd3, 16'h0807);
    load_word(5'd4, 16'hF800);
    push(16'h0809, 5'd0);
    push(16'h0802, 5'd1);
    push(16'h2000, 5'd2);
    push(16'h0807, 5'd3);
    ifc.instr_ready = 1'b1;
    // Write and start in the same cycle: the first fetch sees the new word.
    load_en = 1'b1; load_addr = 5'd0; load_data = 16'h0809;
    start   = 1'b1;
    tick();
    start = 1'b0;
    // Write attempt while busy must be ignored.
    load_addr = 5'd2; load_data = 16'h1234;
    tick();
    load_en = 1'b0;
    wait_halt("reload");
    checks++;
    if (sb.size() != 0 || ifc.pc !== 5'd4) begin
      errors++;
      $display("FAIL reload_end: got pending=%0d pc=%0d, expected 0 4", sb.size(), ifc.pc);
    end
  endtask

  initial begin
    ifc.instr_ready = 1'b0;
    ifc.pc_load     = 1'b0;
    ifc.pc_target   = '0;
    test_reset();
    test_basic_program();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_halt_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
# instr_issuer

Instruction issuer that drives the `cpu` `instruction` input from a loadable program memory. It holds a program counter, fetches 16-bit words formatted as {opcode[4:0], imm[10:0]} and presents them to the CPU over a valid/ready handshake. It follows CPU-requested PC redirects (CALL/RET/jumps) and stops on a HALT opcode. It is the producer end of the instruction interface that the CPU consumes, and replaces hand-timed testbench stimulus.

## Interface
- WIDTH_DATA, 16, instruction word width (opcode is the top 5 bits).
- AWIDTH, 5, program address width; memory depth is 2^AWIDTH words.
- HALT_OP, 5'd31, opcode that stops issue. A word with this opcode is never issued.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  program write strobe; honoured only in IDLE or HALT.
- load_addr  in  AWIDTH  program write address.
- load_data  in  WIDTH_DATA  program write data.
- start  in  1  begin execution at address 0; honoured only in IDLE or HALT.
- instr_ready  in  1  CPU accepts `instruction` this cycle.
- pc_load  in  1  CPU redirect request (one-cycle pulse).
- pc_target  in  AWIDTH  redirect address.
- instruction  out  WIDTH_DATA  issued word; registered.
- instr_valid  out  1  `instruction` is valid.
- pc  out  AWIDTH  address of the word being fetched or issued.
- busy  out  1  high in FETCH or ISSUE.
- halted  out  1  high in HALT.

## Operation
- Memory: 2^AWIDTH x WIDTH_DATA with synchronous write and synchronous read. Contents are not cleared by reset.
- States:
  - IDLE: start -> FETCH, with pc <= 0.
  - FETCH: read mem[pc].
    - If the read word's opcode == HALT_OP -> HALT; instr_valid stays 0.
    - Otherwise -> ISSUE; instruction <= word, instr_valid <= 1.
  - ISSUE: hold the word until instr_valid && instr_ready (transfer).
    - On transfer: pc <= pc+1 modulo 2^AWIDTH, then -> FETCH.
  - HALT: start -> FETCH with pc <= 0. load_en is allowed.
- Handshake: while instr_valid=1 and instr_ready=0, `instruction` and `pc` hold stable. instr_valid never drops without a transfer, except on redirect or reset.
- Redirect: pc_load is honoured in FETCH and ISSUE and ignored in IDLE and HALT. It sets pc <= pc_target, forces instr_valid <= 0 and goes to FETCH.
  - pc_load while the word is pending (no transfer): the pending word is discarded.
  - pc_load in the same cycle as a transfer: the transfer counts, and pc_target overrides pc+1.
  - pc_load in FETCH: the in-flight read is discarded.
- Wrap-around: pc increments from 2^AWIDTH-1 to 0; no error flag.
- load_en together with start in IDLE/HALT: the write happens in that cycle, and the following FETCH sees the written data.
- start while busy is ignored. load_en while busy is ignored and memory is unchanged.

## Timing
- Reset values: instruction=0, instr_valid=0, pc=0, busy=0, halted=0, state IDLE. Reset takes effect immediately, mid-transfer included.
- start sampled at edge t:
  - FETCH during t..t+1.
  - instr_valid=1 after edge t+2.
- With instr_ready tied high, one word is issued every 2 cycles: valid after edges t+2, t+4, t+6, ...
- Redirect sampled at edge r: the new word is valid after edge r+2.
- HALT_OP reached: the FETCH edge moves the block to HALT, and halted=1 after that edge. pc stays at the HALT word's address.
- instr_valid rises only on a clock edge. There is no combinational path from instr_ready or pc_load to any output.

## Test plan
- Load 0x0805, 0x0802, 0x2000, 0xF800 at addresses 0-3, hold instr_ready=1, pulse start -> instruction reads 0x0805, 0x0802, 0x2000 in consecutive ISSUE cycles 2 clocks apart; then halted=1, pc=3, instr_valid=0; 0xF800 is never valid.
- Same program, instr_ready=0 for 3 cycles while 0x0805 is pending -> instruction holds 0x0805 with valid=1 and pc=0 throughout; the next word is 0x0802 after ready rises.
- Pulse pc_load with pc_target=0 while 0x0802 is pending -> 0x0802 is dropped; 0x0805 is valid 2 cycles later with pc=0. Repeat with pc_load coincident with the transfer of 0x0802 -> next word 0x0805.
- Load 0x0801 at address 31 and 0x0803 at address 0 (no halt in range), redirect to 31 -> 0x0801 is issued with pc=31, then pc wraps to 0 and 0x0803 is issued.
- Assert reset low mid-ISSUE -> instr_valid=0, pc=0, instruction=0 without waiting for a clock edge. After release the block is IDLE; a second start replays the program from address 0 with memory intact.
- In HALT, load 0x0807 at address 3 and pulse start -> the program reruns and 0x0807 is issued fourth; load_en pulsed while busy leaves memory unchanged.
